// File: rtl/multi_collision_detector.sv
// -----------------------------------------------------------------------------
// multi_collision_detector
//
// Purpose:
//   Per-frame player-vs-bullet hit test over N_BULLETS slots. A scan snapshots
//   all positions on the start edge, then evaluates one slot per clock with a
//   single shared comparator. Results (mask, lowest hit index, damage pulse,
//   saturating damage count) update together on the final edge with a
//   one-cycle done pulse.
//
// Optional feature macro: COLLISION_IFRAME_EN
//   When defined, an 8-bit invincibility counter suppresses damage for
//   IFRAME_SCANS completed scans after a damaging scan. When undefined,
//   invincible is tied low and every scan with an overlap deals damage.
//
// Ports:
//   CLOCK_50       in   system clock, rising edge
//   reset          in   asynchronous active-high reset
//   start          in   scan request, sampled only while idle
//   player_x/y     in   player top-left corner
//   bullet_x_bus   in   slot i x = [i*X_W +: X_W]
//   bullet_y_bus   in   slot i y = [i*Y_W +: Y_W]
//   bullet_active  in   per-slot live flag; inactive slots never hit
//   busy           out  high while scanning or finishing
//   done           out  one-cycle pulse when results update
//   hit_mask       out  per-slot overlap of the last scan
//   first_hit_idx  out  lowest set bit of hit_mask, 0 if none
//   damage         out  one-cycle pulse with done: overlap and not invincible
//   hit_total      out  damage pulse count, saturating at 255
//   invincible     out  invincibility counter nonzero
// -----------------------------------------------------------------------------
module multi_collision_detector #(
  parameter int N_BULLETS    = 8,
  parameter int X_W          = 8,
  parameter int Y_W          = 7,
  parameter int PLAYER_W     = 8,
  parameter int PLAYER_H     = 8,
  parameter int BULLET_W     = 8,
  parameter int BULLET_H     = 4,
  parameter int IFRAME_SCANS = 30,
  localparam int IDXW        = $clog2(N_BULLETS)
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     start,
  input  logic [X_W-1:0]           player_x,
  input  logic [Y_W-1:0]           player_y,
  input  logic [N_BULLETS*X_W-1:0] bullet_x_bus,
  input  logic [N_BULLETS*Y_W-1:0] bullet_y_bus,
  input  logic [N_BULLETS-1:0]     bullet_active,
  output logic                     busy,
  output logic                     done,
  output logic [N_BULLETS-1:0]     hit_mask,
  output logic [IDXW-1:0]          first_hit_idx,
  output logic                     damage,
  output logic [7:0]               hit_total,
  output logic                     invincible
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCAN   = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  // Box extents widened by one bit so sums near the screen edge cannot wrap.
  localparam logic [X_W:0] PW_EXT = (X_W+1)'(PLAYER_W);
  localparam logic [X_W:0] BW_EXT = (X_W+1)'(BULLET_W);
  localparam logic [Y_W:0] PH_EXT = (Y_W+1)'(PLAYER_H);
  localparam logic [Y_W:0] BH_EXT = (Y_W+1)'(BULLET_H);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_BULLETS - 1);

  // Reject configurations the counter/index widths cannot represent.
  if (N_BULLETS < 2 || IFRAME_SCANS > 255 || IFRAME_SCANS < 0) begin : g_bad_cfg
    $error("multi_collision_detector: unsupported parameter set");
  end

  logic [1:0]                 r_state;
  logic [IDXW-1:0]            r_idx;
  logic [X_W-1:0]             r_px;
  logic [Y_W-1:0]             r_py;
  logic [N_BULLETS*X_W-1:0]   r_bx_bus;
  logic [N_BULLETS*Y_W-1:0]   r_by_bus;
  logic [N_BULLETS-1:0]       r_act;
  logic [N_BULLETS-1:0]       r_scratch;
  logic [N_BULLETS-1:0]       r_hit_mask;
  logic [IDXW-1:0]            r_first;
  logic                       r_done;
  logic                       r_damage;
  logic [7:0]                 r_total;

  logic [X_W-1:0]             w_bx;
  logic [Y_W-1:0]             w_by;
  logic                       w_slot_hit;
  logic [IDXW-1:0]            w_first;
  logic                       w_inv;
  logic                       w_dmg;

  // Single comparator, steered to the slot under evaluation.
  assign w_bx = r_bx_bus[r_idx*X_W +: X_W];
  assign w_by = r_by_bus[r_idx*Y_W +: Y_W];

  // Strict compares: boxes that only share an edge do not overlap.
  assign w_slot_hit = r_act[r_idx]
                    & ({1'b0, r_px} <  ({1'b0, w_bx} + BW_EXT))
                    & (({1'b0, r_px} + PW_EXT) > {1'b0, w_bx})
                    & ({1'b0, r_py} <  ({1'b0, w_by} + BH_EXT))
                    & (({1'b0, r_py} + PH_EXT) > {1'b0, w_by});

  // Lowest set bit of the completed scan mask; descending loop so the
  // lowest index is written last.
  always_comb begin
    w_first = '0;
    for (int i = N_BULLETS - 1; i >= 0; i--) begin
      if (r_scratch[i]) w_first = IDXW'(i);
    end
  end

  assign w_dmg = (|r_scratch) & ~w_inv;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_px       <= '0;
      r_py       <= '0;
      r_bx_bus   <= '0;
      r_by_bus   <= '0;
      r_act      <= '0;
      r_scratch  <= '0;
      r_hit_mask <= '0;
      r_first    <= '0;
      r_done     <= 1'b0;
      r_damage   <= 1'b0;
      r_total    <= '0;
    end else begin
      r_done   <= 1'b0;
      r_damage <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_px      <= player_x;
            r_py      <= player_y;
            r_bx_bus  <= bullet_x_bus;
            r_by_bus  <= bullet_y_bus;
            r_act     <= bullet_active;
            r_idx     <= '0;
            r_scratch <= '0;
            r_state   <= S_SCAN;
          end
        end
        S_SCAN: begin
          r_scratch[r_idx] <= w_slot_hit;
          r_idx            <= r_idx + IDXW'(1);
          if (r_idx == LAST_IDX) r_state <= S_FINISH;
        end
        S_FINISH: begin
          r_hit_mask <= r_scratch;
          r_first    <= w_first;
          r_done     <= 1'b1;
          r_damage   <= w_dmg;
          if (w_dmg && (r_total != 8'hFF)) r_total <= r_total + 8'd1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef COLLISION_IFRAME_EN
  localparam logic [7:0] IFRAME_LOAD = 8'(IFRAME_SCANS);
  logic [7:0] r_iframe;

  // Counts completed scans, so it only moves on the FINISH edge; the scan
  // that deals damage therefore already reports invincible alongside done.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_iframe <= '0;
    end else if (r_state == S_FINISH) begin
      if (w_dmg)                r_iframe <= IFRAME_LOAD;
      else if (r_iframe != '0)  r_iframe <= r_iframe - 8'd1;
    end
  end

  assign w_inv = (r_iframe != '0);
`else
  assign w_inv = 1'b0;
`endif

  assign busy          = (r_state == S_SCAN) || (r_state == S_FINISH);
  assign done          = r_done;
  assign hit_mask      = r_hit_mask;
  assign first_hit_idx = r_first;
  assign damage        = r_damage;
  assign hit_total     = r_total;
  assign invincible    = w_inv;

endmodule
